cpu_commit_sb: RTL
==================

Name: cpu_commit_sb

Overview:
- Memory commit stage, second generation: translates a virtual address through a parametrised fully-associative TLB and owns the single port to the data cache.
- Stores are buffered in an SB_DEPTH-entry in-order store buffer and drained to the cache in the background.
- Loads arbitrate against the drain, and SB-hazarding loads are ordered behind older stores.
- Sits between the execute/writeback pipeline (valid/ready request, single-pulse response) and the data cache (level request, hit response).

Parameters:
VADDR_WIDTH, 32, virtual address bits
PADDR_WIDTH, 20, physical address bits
PAGE_WIDTH, 12, page offset bits; VPN = VADDR_WIDTH-PAGE_WIDTH, PPN = PADDR_WIDTH-PAGE_WIDTH
DATA_WIDTH, 32, word width; byte lanes = DATA_WIDTH/8
TLB_ENTRIES, 4, TLB entries, >=1
SB_DEPTH, 4, store buffer entries, power of two, >=2

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&&ready
req_write  in  1  1=store, 0=load
req_mode  in  1  1=byte, 0=word
req_addr  in  VADDR_WIDTH  virtual address
req_data  in  DATA_WIDTH  store data (byte in [7:0])
tlb_enable  in  1  translate; 0 = addr[PADDR_WIDTH-1:0] used directly
tlb_write  in  1  install tlb_vaddr->tlb_paddr
tlb_vaddr  in  VADDR_WIDTH  VPN source
tlb_paddr  in  PADDR_WIDTH  PPN source
resp_valid  out  1  one-cycle completion pulse
resp_fault  out  1  TLB miss, no memory effect
resp_data  out  DATA_WIDTH  load data (byte zero-extended)
cache_read  out  1  held until cache_hit
cache_write  out  1  held until cache_hit
cache_mode  out  1  byte/word
cache_addr  out  PADDR_WIDTH  physical address
cache_wdata  out  DATA_WIDTH  write data
cache_hit  in  1  completes the current cache op
cache_rdata  in  DATA_WIDTH  read data, valid with cache_hit
sb_empty  out  1  store buffer empty (fence support)

Behaviour:
- Reset: all outputs 0 except req_ready=1 and sb_empty=1; TLB valid bits cleared, replacement pointer 0, SB pointers 0, FSM IDLE. Reset mid-operation discards SB contents and any in-flight load; cache lines are dropped without a response.
- TLB: combinational lookup on req_addr VPN. tlb_write overwrites the matching entry if present, else the round-robin victim, and advances the pointer modulo TLB_ENTRIES. Lookup in the same cycle as tlb_write sees pre-write contents.
- FSM states: IDLE, LOAD_WAIT, HAZARD_DRAIN.
- req_ready=1 only in IDLE, and for stores only when SB not full.
- Fault: accepted request with tlb_enable=1 and TLB miss -> resp_valid=1, resp_fault=1 next cycle; SB untouched.
- Store accept -> entry {paddr, data, mode} enqueued at tail; resp_valid (ack) next cycle.
- Load accept, no SB word-address match -> LOAD_WAIT; cache_read asserted from the next cycle.
- Load accept with SB word-address match -> HAZARD_DRAIN until the youngest matching entry retires, then LOAD_WAIT.
- LOAD_WAIT: on cache_hit, resp_valid=1 and resp_data=cache_rdata in the cycle after the hit; return to IDLE.
- Drain: when the FSM is not in LOAD_WAIT and the SB is non-empty, present the head entry on cache_write. On cache_hit, pop the head.
- A drain in progress is never preempted: a load reaching LOAD_WAIT waits for the current write's hit before asserting cache_read.
- cache_read and cache_write are never asserted together.
- Pointers are log2(SB_DEPTH)+1 bits and wrap. Full when indices are equal and wrap bits differ; empty when both are equal.
- Enqueue and pop in the same cycle are both performed; count is unchanged.

Optional Feature:
- Macro: CPU_COMMIT_SB_FORWARD_EN.
- Defined: a word load whose youngest SB match is a word-mode entry completes from the SB. resp_data is that entry's data, resp_valid is next cycle, and no cache access is made.
- Defined, byte-mode match: HAZARD_DRAIN as usual.
- Undefined: every SB match takes HAZARD_DRAIN.

Decomposition:
- Shared package cpu_commit_pkg: sb_entry_t {paddr, data, mode}, commit_state_t enum, helper width localparams VPN_W/PPN_W.
- Sub-module cpu_commit_tlb: parametrised fully-associative CAM with round-robin replacement and hit/ppn outputs.

Test Plan:
- TLB miss: tlb_enable=1, load 0x0000_3004 with TLB empty -> resp_fault=1 one cycle later, no cache_read.
- Translation: tlb_write 0x0000_3000->0x5000, load 0x3004 -> cache_addr=0x05004; hit with 0xDEADBEEF -> resp_data=0xDEADBEEF.
- SB full: 4 stores with cache_hit held 0 -> 5th store sees req_ready=0. One hit -> ready=1, stores reach the cache in order 0,1,2,3.
- Hazard: store word 0xAABBCCDD to 0x100, load 0x100 -> cache_write@0x100 precedes cache_read@0x100. With CPU_COMMIT_SB_FORWARD_EN: resp_data=0xAABBCCDD, no cache_read.
- Replacement: 5 tlb_writes with TLB_ENTRIES=4 -> first VPN misses, others hit; rewriting an existing VPN evicts nothing.
- Reset mid-drain: 3 queued stores, reset -> sb_empty=1 and cache_write=0 the next cycle.

Source files
------------

// File: rtl/cpu_commit_pkg.sv
// ============================================================================
//  Module   : cpu_commit_pkg
//  Brief    : Shared types and widths for the cpu_commit_sb memory commit stage
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_commit_pkg;

  // Default geometry; the SB entry layout is sized from these.
  localparam int VADDR_W = 32;
  localparam int PADDR_W = 20;
  localparam int PAGE_W  = 12;
  localparam int DATA_W  = 32;
  localparam int VPN_W   = VADDR_W - PAGE_W;
  localparam int PPN_W   = PADDR_W - PAGE_W;
  localparam int LANE_W  = $clog2(DATA_W / 8);

  // One buffered store.
  typedef struct packed {
    logic [PADDR_W-1:0] paddr;
    logic [DATA_W-1:0]  data;
    logic               mode;
  } sb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_LOAD_WAIT    = 2'd1,
    ST_HAZARD_DRAIN = 2'd2
  } commit_state_t;

  // Word address used for hazard matching (byte lanes stripped).
  function automatic logic [PADDR_W-LANE_W-1:0] word_of(input logic [PADDR_W-1:0] a);
    return a[PADDR_W-1:LANE_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_commit_tlb.sv
// ============================================================================
//  Module   : cpu_commit_tlb
//  Brief    : Fully-associative TLB with round-robin replacement
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_commit_tlb #(
  parameter int VADDR_WIDTH = 32,
  parameter int PADDR_WIDTH = 20,
  parameter int PAGE_WIDTH  = 12,
  parameter int TLB_ENTRIES = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [VADDR_WIDTH-1:0]        lookup_vaddr,
  output logic                          lookup_hit,
  output logic [PADDR_WIDTH-PAGE_WIDTH-1:0] lookup_ppn,
  input  logic                          wr_en,
  input  logic [VADDR_WIDTH-1:0]        wr_vaddr,
  input  logic [PADDR_WIDTH-1:0]        wr_paddr
);

  localparam int VPN_BITS = VADDR_WIDTH - PAGE_WIDTH;
  localparam int PPN_BITS = PADDR_WIDTH - PAGE_WIDTH;
  localparam int PTR_W    = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

  logic [TLB_ENTRIES-1:0] valid_q, valid_d;
  logic [VPN_BITS-1:0]    vpn_q [TLB_ENTRIES];
  logic [VPN_BITS-1:0]    vpn_d [TLB_ENTRIES];
  logic [PPN_BITS-1:0]    ppn_q [TLB_ENTRIES];
  logic [PPN_BITS-1:0]    ppn_d [TLB_ENTRIES];
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       w_wr_idx;
  logic                   w_unused_page_bits;

  assign w_unused_page_bits = ^{lookup_vaddr[PAGE_WIDTH-1:0], wr_vaddr[PAGE_WIDTH-1:0],
                                wr_paddr[PAGE_WIDTH-1:0]};

  // CAM lookup against current (pre-write) contents.
  always_comb begin
    lookup_hit = 1'b0;
    lookup_ppn = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (valid_q[i] && vpn_q[i] == lookup_vaddr[VADDR_WIDTH-1:PAGE_WIDTH]) begin
        lookup_hit = 1'b1;
        lookup_ppn = ppn_q[i];
      end
    end
  end

  // Install: overwrite a matching VPN, otherwise the round-robin victim.
  always_comb begin
    w_wr_idx = ptr_q;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (valid_q[i] && vpn_q[i] == wr_vaddr[VADDR_WIDTH-1:PAGE_WIDTH]) begin
        w_wr_idx = PTR_W'(i);
      end
    end
    valid_d = valid_q;
    vpn_d   = vpn_q;
    ppn_d   = ppn_q;
    ptr_d   = ptr_q;
    if (wr_en) begin
      valid_d[w_wr_idx] = 1'b1;
      vpn_d[w_wr_idx]   = wr_vaddr[VADDR_WIDTH-1:PAGE_WIDTH];
      ppn_d[w_wr_idx]   = wr_paddr[PADDR_WIDTH-1:PAGE_WIDTH];
      ptr_d = (ptr_q == PTR_W'(TLB_ENTRIES - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  // Valid bits and replacement pointer are reset; tags/data need not be.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  // Tag and PPN storage.
  always_ff @(posedge clock) begin
    vpn_q <= vpn_d;
    ppn_q <= ppn_d;
  end

endmodule

`default_nettype wire

// File: rtl/cpu_commit_sb.sv
// ============================================================================
//  Module   : cpu_commit_sb
//  Brief    : Memory commit stage: TLB translation, in-order store buffer
//             drained in the background, loads ordered behind hazarding stores.
//             Optional macro CPU_COMMIT_SB_FORWARD_EN forwards word loads from
//             a matching word-mode store buffer entry.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_commit_sb
  import cpu_commit_pkg::*;
#(
  parameter int VADDR_WIDTH = 32,
  parameter int PADDR_WIDTH = 20,
  parameter int PAGE_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int TLB_ENTRIES = 4,
  parameter int SB_DEPTH    = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic                   req_mode,
  input  logic [VADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]  req_data,
  input  logic                   tlb_enable,
  input  logic                   tlb_write,
  input  logic [VADDR_WIDTH-1:0] tlb_vaddr,
  input  logic [PADDR_WIDTH-1:0] tlb_paddr,
  output logic                   resp_valid,
  output logic                   resp_fault,
  output logic [DATA_WIDTH-1:0]  resp_data,
  output logic                   cache_read,
  output logic                   cache_write,
  output logic                   cache_mode,
  output logic [PADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0]  cache_wdata,
  input  logic                   cache_hit,
  input  logic [DATA_WIDTH-1:0]  cache_rdata,
  output logic                   sb_empty
);

  localparam int SB_AW = $clog2(SB_DEPTH);
  localparam int PTR_W = SB_AW + 1;

  commit_state_t          state_q, state_d;
  sb_entry_t              sb_q [SB_DEPTH];
  sb_entry_t              sb_d [SB_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, hz_ptr_q, hz_ptr_d;
  logic [PADDR_WIDTH-1:0] load_paddr_q, load_paddr_d;
  logic                   load_mode_q, load_mode_d;
  logic                   wr_busy_q, wr_busy_d;
  logic                   resp_valid_q, resp_valid_d, resp_fault_q, resp_fault_d;
  logic [DATA_WIDTH-1:0]  resp_data_q, resp_data_d;

  logic                            w_tlb_hit;
  logic [PADDR_WIDTH-PAGE_WIDTH-1:0] w_tlb_ppn;
  logic [PADDR_WIDTH-1:0]          w_paddr;
  logic                            w_fault, w_accept, w_full, w_push, w_pop;
  logic [PTR_W-1:0]                w_count, w_kptr, w_match_ptr;
  logic                            w_match;
  sb_entry_t                       w_head;

  cpu_commit_tlb #(
    .VADDR_WIDTH (VADDR_WIDTH),
    .PADDR_WIDTH (PADDR_WIDTH),
    .PAGE_WIDTH  (PAGE_WIDTH),
    .TLB_ENTRIES (TLB_ENTRIES)
  ) u_tlb (
    .clock        (clock),
    .reset        (reset),
    .lookup_vaddr (req_addr),
    .lookup_hit   (w_tlb_hit),
    .lookup_ppn   (w_tlb_ppn),
    .wr_en        (tlb_write),
    .wr_vaddr     (tlb_vaddr),
    .wr_paddr     (tlb_paddr)
  );

  assign w_paddr  = tlb_enable ? {w_tlb_ppn, req_addr[PAGE_WIDTH-1:0]} : req_addr[PADDR_WIDTH-1:0];
  assign w_fault  = tlb_enable && !w_tlb_hit;
  assign w_count  = wr_ptr_q - rd_ptr_q;
  assign sb_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full   = (wr_ptr_q[SB_AW-1:0] == rd_ptr_q[SB_AW-1:0]) &&
                    (wr_ptr_q[SB_AW] != rd_ptr_q[SB_AW]);
  assign w_head   = sb_q[rd_ptr_q[SB_AW-1:0]];

  assign req_ready = (state_q == ST_IDLE) && (!req_write || !w_full);
  assign w_accept  = req_valid && req_ready;

  // A write once presented stays up until its hit, even if a load is now waiting.
  assign cache_write = !sb_empty && ((state_q != ST_LOAD_WAIT) || wr_busy_q);
  assign cache_read  = (state_q == ST_LOAD_WAIT) && !cache_write;
  assign cache_addr  = cache_write ? w_head.paddr : (cache_read ? load_paddr_q : '0);
  assign cache_mode  = cache_write ? w_head.mode  : (cache_read && load_mode_q);
  assign cache_wdata = cache_write ? w_head.data  : '0;
  assign w_pop       = cache_write && cache_hit;
  assign wr_busy_d   = cache_write && !cache_hit;

  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign resp_data  = resp_data_q;

  // Youngest SB entry sharing the request's word address; a head leaving this cycle is skipped.
  always_comb begin
    w_match     = 1'b0;
    w_match_ptr = rd_ptr_q;
    w_kptr      = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      w_kptr = rd_ptr_q + PTR_W'(k);
      if ((PTR_W'(k) < w_count) && !(k == 0 && w_pop) &&
          (word_of(sb_q[w_kptr[SB_AW-1:0]].paddr) == word_of(w_paddr))) begin
        w_match     = 1'b1;
        w_match_ptr = w_kptr;
      end
    end
  end

`ifdef CPU_COMMIT_SB_FORWARD_EN
  sb_entry_t w_match_entry;
  assign w_match_entry = sb_q[w_match_ptr[SB_AW-1:0]];
`endif

  // Request acceptance, load sequencing and response generation.
  always_comb begin
    state_d      = state_q;
    hz_ptr_d     = hz_ptr_q;
    load_paddr_d = load_paddr_q;
    load_mode_d  = load_mode_q;
    resp_valid_d = 1'b0;
    resp_fault_d = 1'b0;
    resp_data_d  = '0;
    w_push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_fault) begin
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else if (req_write) begin
            w_push       = 1'b1;
            resp_valid_d = 1'b1;
          end else begin
            load_paddr_d = w_paddr;
            load_mode_d  = req_mode;
            if (!w_match) begin
              state_d = ST_LOAD_WAIT;
`ifdef CPU_COMMIT_SB_FORWARD_EN
            end else if (!req_mode && !w_match_entry.mode) begin
              resp_valid_d = 1'b1;
              resp_data_d  = w_match_entry.data;
`endif
            end else begin
              state_d  = ST_HAZARD_DRAIN;
              hz_ptr_d = w_match_ptr;
            end
          end
        end
      end
      ST_LOAD_WAIT: begin
        if (cache_read && cache_hit) begin
          resp_valid_d = 1'b1;
          resp_data_d  = load_mode_q ? {{(DATA_WIDTH-8){1'b0}}, cache_rdata[7:0]} : cache_rdata;
          state_d      = ST_IDLE;
        end
      end
      ST_HAZARD_DRAIN: begin
        if (w_pop && (rd_ptr_q == hz_ptr_q)) begin
          state_d = ST_LOAD_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Store buffer enqueue at tail, pop at head; both may happen together.
  always_comb begin
    sb_d     = sb_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(w_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(w_pop);
    if (w_push) begin
      sb_d[wr_ptr_q[SB_AW-1:0]] = '{paddr: w_paddr, data: req_data, mode: req_mode};
    end
  end

  // Control and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      hz_ptr_q     <= '0;
      load_paddr_q <= '0;
      load_mode_q  <= 1'b0;
      wr_busy_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      hz_ptr_q     <= hz_ptr_d;
      load_paddr_q <= load_paddr_d;
      load_mode_q  <= load_mode_d;
      wr_busy_q    <= wr_busy_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Store buffer payload storage.
  always_ff @(posedge clock) begin
    sb_q <= sb_d;
  end

endmodule

`default_nettype wire
